// File: rtl/aidan_mcnay_prime_seq_if.sv
// Candidate, result and divider streams of the prime sequencer.
// slave = sequencer side, master = environment side.
interface aidan_mcnay_prime_seq_if #(
  parameter int nbits = 16
);
  logic [nbits-1:0] num;
  logic             istream_val;
  logic             istream_rdy;
  logic             is_prime;
  logic             ostream_val;
  logic             ostream_rdy;
  logic [nbits-1:0] div_opa;
  logic [nbits-1:0] div_opb;
  logic             div_istream_val;
  logic             div_istream_rdy;
  logic [nbits-1:0] div_result;
  logic             div_ostream_val;
  logic             div_ostream_rdy;

  modport slave (
    input  num, istream_val, ostream_rdy,
    input  div_istream_rdy, div_result, div_ostream_val,
    output istream_rdy, is_prime, ostream_val,
    output div_opa, div_opb, div_istream_val, div_ostream_rdy
  );

  modport master (
    output num, istream_val, ostream_rdy,
    output div_istream_rdy, div_result, div_ostream_val,
    input  istream_rdy, is_prime, ostream_val,
    input  div_opa, div_opb, div_istream_val, div_ostream_rdy
  );
endinterface

// File: rtl/aidan_mcnay_prime_seq.sv
// Trial-division primality sequencer driving one shared divider.
// Divisor square is tracked incrementally at double width.
module aidan_mcnay_prime_seq #(
  parameter int nbits = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  aidan_mcnay_prime_seq_if.slave  io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [nbits-1:0]   r_n;
  logic [nbits-1:0]   r_d;
  logic [2*nbits-1:0] r_dsq;
  logic               r_prime;

  logic [2*nbits-1:0] w_n_wide;
  logic [2*nbits-1:0] w_dsq_inc;
  logic [nbits-1:0]   w_d_inc;
  logic               w_lt2;
  logic               w_dsq_gt;
  logic               w_rem_zero;

  assign w_n_wide   = {{nbits{1'b0}}, r_n};
  assign w_dsq_inc  = r_dsq + {{(nbits-1){1'b0}}, r_d, 1'b1};
  assign w_d_inc    = r_d + nbits'(1);
  assign w_lt2      = (r_n < nbits'(2));
  assign w_dsq_gt   = (r_dsq > w_n_wide);
  assign w_rem_zero = (io.div_result == '0);

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next state and handshake outputs, all forced low in reset
  always_comb begin
    w_next             = r_state;
    io.istream_rdy     = 1'b0;
    io.ostream_val     = 1'b0;
    io.is_prime        = 1'b0;
    io.div_istream_val = 1'b0;
    io.div_ostream_rdy = 1'b0;
    io.div_opa         = r_n;
    io.div_opb         = r_d;
    unique case (r_state)
      S_IDLE: begin
        io.istream_rdy = 1'b1;
        if (io.istream_val) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_lt2 || w_dsq_gt) w_next = S_DONE;
        else                   w_next = S_ISSUE;
      end
      S_ISSUE: begin
        io.div_istream_val = 1'b1;
        if (io.div_istream_rdy) w_next = S_WAIT;
      end
      S_WAIT: begin
        io.div_ostream_rdy = 1'b1;
        if (io.div_ostream_val) begin
          if (w_rem_zero) w_next = S_DONE;
          else            w_next = S_CHECK;
        end
      end
      S_DONE: begin
        io.ostream_val = 1'b1;
        io.is_prime    = r_prime;
        if (io.ostream_rdy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (reset) begin
      w_next             = S_IDLE;
      io.istream_rdy     = 1'b0;
      io.ostream_val     = 1'b0;
      io.is_prime        = 1'b0;
      io.div_istream_val = 1'b0;
      io.div_ostream_rdy = 1'b0;
    end
  end

  // candidate, divisor, divisor square and verdict
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n     <= '0;
      r_d     <= '0;
      r_dsq   <= '0;
      r_prime <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (io.istream_val) begin
            r_n     <= io.num;
            r_d     <= nbits'(2);
            r_dsq   <= (2*nbits)'(4);
            r_prime <= 1'b0;
          end
        end
        S_CHECK: begin
          if (w_lt2)         r_prime <= 1'b0;
          else if (w_dsq_gt) r_prime <= 1'b1;
        end
        S_WAIT: begin
          if (io.div_ostream_val) begin
            if (w_rem_zero) begin
              r_prime <= 1'b0;
            end else begin
              r_dsq <= w_dsq_inc;
              r_d   <= w_d_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aidan_mcnay_prime_seq.sv
// Bench for the prime sequencer: behavioural divider with random
// latency, scoreboard of expected verdicts and request counts.
module tb_aidan_mcnay_prime_seq;

  localparam int NB = 16;

  typedef struct {
    logic prime;
    int   nreq;
    int   lat;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aidan_mcnay_prime_seq_if #(.nbits(NB)) bus();

  aidan_mcnay_prime_seq #(.nbits(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  res_t obs_a[0:255];
  int   rd_idx   = 0;

  int          cyc      = 0;
  int          acc_cnt  = 0;
  int          tot_req  = 0;
  int          tot_out  = 0;
  int          cur_req  = 0;
  int          cur_d    = 0;
  int          acc_cyc  = 0;
  logic [15:0] cur_n    = '0;
  int          bad_req  = 0;
  int          stab_err = 0;
  bit          pend     = 0;
  logic [15:0] prem     = '0;
  int          lat_req  = 0;
  bit          p_req_st = 0;
  bit          p_out_st = 0;
  logic [15:0] p_opa    = '0;
  logic [15:0] p_opb    = '0;
  logic        p_prime  = 0;

  int fix_lat = -1;
  bit bp      = 0;

  int dcnt     = 0;
  int seen_id  = -1;
  int div_st   = 0;
  int sink_st  = 0;
  int dtag     = -1;
  int stag     = -1;

  function automatic res_t model(input int n);
    res_t r;
    r.prime = (n >= 2);
    r.nreq  = 0;
    r.lat   = 0;
    for (int d = 2; d * d <= n; d++) begin
      r.nreq++;
      if (n % d == 0) begin
        r.prime = 1'b0;
        break;
      end
    end
    return r;
  endfunction

  // monitor: handshakes and stability sampled before the edge updates state
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pend     = 0;
      p_req_st = 0;
      p_out_st = 0;
    end else begin
      if (p_req_st && (!bus.div_istream_val || bus.div_opa !== p_opa ||
                       bus.div_opb !== p_opb))
        stab_err++;
      if (p_out_st && (!bus.ostream_val || bus.is_prime !== p_prime))
        stab_err++;
      p_req_st = bus.div_istream_val && !bus.div_istream_rdy;
      p_opa    = bus.div_opa;
      p_opb    = bus.div_opb;
      p_out_st = bus.ostream_val && !bus.ostream_rdy;
      p_prime  = bus.is_prime;
      if (bus.istream_val && bus.istream_rdy) begin
        acc_cnt++;
        cur_n   = bus.num;
        cur_req = 0;
        cur_d   = 2;
        acc_cyc = cyc;
      end
      if (bus.div_ostream_val && bus.div_ostream_rdy)
        pend = 0;
      if (bus.div_istream_val && bus.div_istream_rdy) begin
        if (pend) bad_req++;
        if (bus.div_opa !== cur_n || bus.div_opb !== 16'(cur_d))
          bad_req++;
        cur_req++;
        cur_d++;
        tot_req++;
        pend    = 1;
        prem    = (bus.div_opb == 0) ? bus.div_opa
                                     : bus.div_opa % bus.div_opb;
        lat_req = (fix_lat >= 0) ? fix_lat : $urandom_range(0, 20);
      end
      if (bus.ostream_val && bus.ostream_rdy) begin
        obs_a[tot_out[7:0]].prime = bus.is_prime;
        obs_a[tot_out[7:0]].nreq  = cur_req;
        obs_a[tot_out[7:0]].lat   = cyc - acc_cyc;
        tot_out++;
      end
    end
  end

  // divider model and sink driver, inputs change on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      bus.div_ostream_val = 1'b0;
      bus.div_result      = '0;
      bus.div_istream_rdy = 1'b1;
      bus.ostream_rdy     = 1'b1;
      div_st  = 0;
      sink_st = 0;
    end else begin
      if (pend && seen_id != tot_req) begin
        seen_id = tot_req;
        dcnt    = lat_req;
      end
      if (pend && dcnt == 0) begin
        bus.div_ostream_val = 1'b1;
        bus.div_result      = prem;
      end else begin
        bus.div_ostream_val = 1'b0;
        bus.div_result      = 16'hdead;
        if (pend) dcnt--;
      end
      if (bp && bus.div_istream_val && dtag != tot_req) begin
        dtag   = tot_req;
        div_st = 4;
      end
      bus.div_istream_rdy = (div_st == 0);
      if (div_st > 0) div_st--;
      if (bp && bus.ostream_val && stag != tot_out) begin
        stag    = tot_out;
        sink_st = 5;
      end
      bus.ostream_rdy = (sink_st == 0);
      if (sink_st > 0) sink_st--;
    end
  end

  task automatic collect(input string nm, input int want_lat);
    res_t e;
    res_t o;
    for (int i = 0; i < 20000 && rd_idx >= tot_out; i++)
      @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (rd_idx >= tot_out) begin
      n_fail++;
      $display("FAIL %s result timeout: got no output, required one", nm);
      return;
    end
    o = obs_a[rd_idx[7:0]];
    rd_idx++;
    n_checks++;
    if (o.prime !== e.prime) begin
      n_fail++;
      $display("FAIL %s is_prime: got %b required %b", nm, o.prime, e.prime);
    end
    n_checks++;
    if (o.nreq !== e.nreq) begin
      n_fail++;
      $display("FAIL %s requests: got %0d required %0d", nm, o.nreq, e.nreq);
    end
    if (want_lat >= 0) begin
      n_checks++;
      if (o.lat !== want_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d required %0d", nm, o.lat, want_lat);
      end
    end
  endtask

  task automatic send(input int n, input string nm);
    int base;
    bit ok;
    exp_q.push_back(model(n));
    bus.num         = 16'(n);
    bus.istream_val = 1'b1;
    base = acc_cnt;
    ok   = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (acc_cnt != base) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s accept timeout: got no handshake, required one", nm);
    end
  endtask

  task automatic run(input int n, input string nm, input int want_lat);
    @(negedge clk);
    send(n, nm);
    bus.istream_val = 1'b0;
    collect(nm, want_lat);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.istream_rdy, bus.ostream_val, bus.div_istream_val,
         bus.div_ostream_rdy, bus.is_prime} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b required 00000",
               {bus.istream_rdy, bus.ostream_val, bus.div_istream_val,
                bus.div_ostream_rdy, bus.is_prime});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.istream_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL idle istream_rdy: got %b required 1", bus.istream_rdy);
    end
  endtask

  task automatic test_small;
    run(0, "n0", -1);
    run(1, "n1", -1);
    run(2, "n2", -1);
    run(3, "n3", -1);
    run(4, "n4", -1);
  endtask

  task automatic test_latency;
    fix_lat = 0;
    run(97, "n97_lat", 26);
    fix_lat = -1;
  endtask

  task automatic test_divisors;
    int r;
    run(97, "n97", -1);
    run(91, "n91", -1);
    fix_lat = 0;
    run(65521, "n65521", 2 + 254 * 3);
    fix_lat = -1;
    run(65535, "n65535", -1);
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 3000);
      run(r, $sformatf("rand%0d", r), -1);
    end
    n_checks++;
    if (bad_req !== 0) begin
      n_fail++;
      $display("FAIL request operands: got %0d bad required 0", bad_req);
    end
  endtask

  task automatic test_backpressure;
    bp = 1;
    run(97, "bp97", -1);
    run(91, "bp91", -1);
    run(3, "bp3", -1);
    bp = 0;
    n_checks++;
    if (stab_err !== 0) begin
      n_fail++;
      $display("FAIL bp stability: got %0d errors required 0", stab_err);
    end
    n_checks++;
    if (bad_req !== 0) begin
      n_fail++;
      $display("FAIL bp requests: got %0d bad required 0", bad_req);
    end
  endtask

  task automatic test_back_to_back;
    int lst[6] = '{13, 25, 2, 49, 101, 1};
    bp = 1;
    @(negedge clk);
    foreach (lst[i]) send(lst[i], $sformatf("b2b%0d", lst[i]));
    bus.istream_val = 1'b0;
    foreach (lst[i]) collect($sformatf("b2b%0d", lst[i]), -1);
    bp = 0;
    n_checks++;
    if (stab_err !== 0) begin
      n_fail++;
      $display("FAIL b2b stability: got %0d errors required 0", stab_err);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    bit hit;
    fix_lat = 3;
    @(negedge clk);
    bus.num         = 16'd97;
    bus.istream_val = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 200 && acc_cnt == base; i++) @(negedge clk);
    bus.istream_val = 1'b0;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.div_ostream_rdy) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid wait state: got no WAIT, required WAIT");
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.istream_rdy, bus.ostream_val, bus.div_istream_val,
         bus.div_ostream_rdy} !== 4'b0) begin
      n_fail++;
      $display("FAIL mid reset outputs: got %b required 0000",
               {bus.istream_rdy, bus.ostream_val, bus.div_istream_val,
                bus.div_ostream_rdy});
    end
    reset = 1'b0;
    base = tot_out;
    repeat (30) @(negedge clk);
    n_checks++;
    if (tot_out !== base) begin
      n_fail++;
      $display("FAIL mid abandoned: got %0d outputs required 0",
               tot_out - base);
    end
    fix_lat = -1;
    run(4, "after_reset4", -1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.num         = '0;
    bus.istream_val = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_small();
    test_latency();
    test_divisors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
